// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: ID/EX control stage for the pipelined MIPS core.
// Decodes a 32-bit instruction word into ALU control, operand-select and
// writeback controls, and buffers the decoded result in a 2-entry elastic
// queue with valid/ready handshakes on both sides plus a synchronous flush.
//
// Build option: define ILLEGAL_TRAP_EN to flag unsupported opcode/funct
// combinations on e_illegal. When it is undefined, e_illegal is tied to 0
// and unsupported words decode silently as a NOP.
//
// Queue organisation: entry e0 is always the head and drives the outputs
// directly, and e1 is the second slot. A pop shifts e1 into e0, so the
// outputs come from flops only and there is no path from inst to any output.

module alu_ctrl_stage #(
    parameter int DEPTH   = 2,
    parameter int RDEST_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         aluc,
    output logic               shift,
    output logic               aluimm,
    output logic [31:0]        imm32,
    output logic [4:0]         sa,
    output logic               wreg,
    output logic [RDEST_W-1:0] rn,
    output logic               m2reg,
    output logic               wmem,
    output logic               e_illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [1:0] FULL = 2'(DEPTH);

    // ALU control codes shared with the EX-stage ALU
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;

    typedef struct packed {
        logic [3:0]         aluc;
        logic               shift;
        logic               aluimm;
        logic [31:0]        imm32;
        logic [4:0]         sa;
        logic               wreg;
        logic [RDEST_W-1:0] rn;
        logic               m2reg;
        logic               wmem;
        logic               illegal;
    } entry_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_rs;

    assign op        = inst[31:26];
    assign funct     = inst[5:0];
    assign rt        = inst[20:16];
    assign rd        = inst[15:11];
    assign unused_rs = ^inst[25:21];

    entry_t     dec;
    logic       sext;
    logic       legal;

    entry_t     e0;
    entry_t     e1;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       push;
    logic       pop;

    // Instruction decode; anything unrecognised stays an all-zero NOP
    always_comb begin
        dec   = '0;
        sext  = 1'b0;
        legal = 1'b1;
        dec.sa = inst[10:6];
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD: begin dec.aluc = ALU_ADD; dec.wreg = 1'b1; dec.rn = RDEST_W'(rd); end
                    F_SUB: begin dec.aluc = ALU_SUB; dec.wreg = 1'b1; dec.rn = RDEST_W'(rd); end
                    F_AND: begin dec.aluc = ALU_AND; dec.wreg = 1'b1; dec.rn = RDEST_W'(rd); end
                    F_OR:  begin dec.aluc = ALU_OR;  dec.wreg = 1'b1; dec.rn = RDEST_W'(rd); end
                    F_XOR: begin dec.aluc = ALU_XOR; dec.wreg = 1'b1; dec.rn = RDEST_W'(rd); end
                    F_SLL: begin
                        dec.aluc  = ALU_SLL;
                        dec.shift = 1'b1;
                        dec.wreg  = 1'b1;
                        dec.rn    = RDEST_W'(rd);
                    end
                    F_SRL: begin
                        dec.aluc  = ALU_SRL;
                        dec.shift = 1'b1;
                        dec.wreg  = 1'b1;
                        dec.rn    = RDEST_W'(rd);
                    end
                    F_SRA: begin
                        dec.aluc  = ALU_SRA;
                        dec.shift = 1'b1;
                        dec.wreg  = 1'b1;
                        dec.rn    = RDEST_W'(rd);
                    end
                    F_JR:    ;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec.aluc   = ALU_ADD;
                dec.aluimm = 1'b1;
                dec.wreg   = 1'b1;
                dec.rn     = RDEST_W'(rt);
                sext       = 1'b1;
            end
            OP_ANDI: begin
                dec.aluc   = ALU_AND;
                dec.aluimm = 1'b1;
                dec.wreg   = 1'b1;
                dec.rn     = RDEST_W'(rt);
            end
            OP_ORI: begin
                dec.aluc   = ALU_OR;
                dec.aluimm = 1'b1;
                dec.wreg   = 1'b1;
                dec.rn     = RDEST_W'(rt);
            end
            OP_XORI: begin
                dec.aluc   = ALU_XOR;
                dec.aluimm = 1'b1;
                dec.wreg   = 1'b1;
                dec.rn     = RDEST_W'(rt);
            end
            OP_LUI: begin
                dec.aluc   = ALU_LUI;
                dec.aluimm = 1'b1;
                dec.wreg   = 1'b1;
                dec.rn     = RDEST_W'(rt);
            end
            OP_LW: begin
                dec.aluc   = ALU_ADD;
                dec.aluimm = 1'b1;
                dec.wreg   = 1'b1;
                dec.m2reg  = 1'b1;
                dec.rn     = RDEST_W'(rt);
                sext       = 1'b1;
            end
            OP_SW: begin
                dec.aluc   = ALU_ADD;
                dec.aluimm = 1'b1;
                dec.wmem   = 1'b1;
                sext       = 1'b1;
            end
            OP_BEQ, OP_BNE: dec.aluc = ALU_SUB;
            OP_J:           ;
            OP_JAL: begin
                dec.aluc = ALU_ADD;
                dec.wreg = 1'b1;
                dec.rn   = RDEST_W'(5'd31);
            end
            default: legal = 1'b0;
        endcase
        dec.imm32   = sext ? {{16{inst[15]}}, inst[15:0]} : {16'h0000, inst[15:0]};
        dec.illegal = TRAP_EN & ~legal;
    end

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);

    // Occupancy after this cycle's handshakes
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: ;
        endcase
    end

    // Queue storage, occupancy and registered in_ready; reset beats flush
    always_ff @(posedge clock) begin
        if (reset) begin
            e0       <= '0;
            e1       <= '0;
            count    <= 2'd0;
            in_ready <= 1'b1;
        end else if (flush) begin
            e0       <= '0;
            e1       <= '0;
            count    <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= dec;
                    else               e1 <= dec;
                end
                2'b01: e0 <= e1;
                2'b11: begin
                    // push is only possible below full, so this is count==1:
                    // the incoming word replaces the departing head
                    if (count == 2'd1) begin
                        e0 <= dec;
                    end else begin
                        e0 <= e1;
                        e1 <= dec;
                    end
                end
                default: ;
            endcase
            count    <= count_next;
            in_ready <= (count_next != FULL);
        end
    end

    assign aluc      = e0.aluc;
    assign shift     = e0.shift;
    assign aluimm    = e0.aluimm;
    assign imm32     = e0.imm32;
    assign sa        = e0.sa;
    assign wreg      = e0.wreg;
    assign rn        = e0.rn;
    assign m2reg     = e0.m2reg;
    assign wmem      = e0.wmem;
    assign e_illegal = e0.illegal;

endmodule
